// File: rtl/serv_wb2axi_arbiter.sv
// Two-requester Wishbone to single-beat AXI4-Lite bridge with one transaction in flight.
// Optional SERV_ARB_ERR_EN macro returns AXI SLVERR/DECERR on s_err alongside s_ack.
module serv_wb2axi_arbiter #(
    parameter int unsigned AW = 13,
    parameter bit          RR = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2*AW-1:0] s_adr,
    input  logic [63:0]     s_dat,
    input  logic [7:0]      s_sel,
    input  logic [1:0]      s_we,
    input  logic [1:0]      s_stb,
    output logic [1:0]      s_ack,
    output logic [1:0]      s_err,
    output logic [31:0]     s_rdt,
    output logic            m_awvalid,
    input  logic            m_awready,
    output logic [AW-1:0]   m_awaddr,
    output logic            m_wvalid,
    input  logic            m_wready,
    output logic [31:0]     m_wdata,
    output logic [3:0]      m_wstrb,
    input  logic            m_bvalid,
    output logic            m_bready,
    input  logic [1:0]      m_bresp,
    output logic            m_arvalid,
    input  logic            m_arready,
    output logic [AW-1:0]   m_araddr,
    input  logic            m_rvalid,
    output logic            m_rready,
    input  logic [31:0]     m_rdata,
    input  logic [1:0]      m_rresp
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WR    = 3'd1;
    localparam logic [2:0] WRESP = 3'd2;
    localparam logic [2:0] RD_A  = 3'd3;
    localparam logic [2:0] RD_D  = 3'd4;
    localparam logic [2:0] ACK   = 3'd5;

    logic [2:0]    state, state_nxt;
    logic          grant, grant_nxt;
    logic          rr_ptr, rr_ptr_nxt;
    logic          pick;
    logic [AW-3:0] adr_q, adr_nxt;
    logic [31:0]   dat_nxt;
    logic [3:0]    sel_nxt;
    logic          aw_nxt, w_nxt;
    logic [1:0]    ack_nxt;
    logic [31:0]   rdt_nxt;
    logic          err_nxt;

    // Word-aligned address shared by both AXI address channels
    assign m_awaddr = {adr_q, 2'b00};
    assign m_araddr = {adr_q, 2'b00};

    // Arbitration: on a tie round-robin favours the requester that was not served last
    always_comb begin
        pick = 1'b0;
        if (s_stb == 2'b01) begin
            pick = 1'b0;
        end else if (s_stb == 2'b10) begin
            pick = 1'b1;
        end else begin
            pick = RR ? ~rr_ptr : 1'b0;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant;
        rr_ptr_nxt = rr_ptr;
        adr_nxt    = adr_q;
        dat_nxt    = m_wdata;
        sel_nxt    = m_wstrb;
        aw_nxt     = 1'b0;
        w_nxt      = 1'b0;
        rdt_nxt    = s_rdt;
        err_nxt    = 1'b0;

        case (state)
            IDLE: begin
                if (|s_stb) begin
                    grant_nxt  = pick;
                    rr_ptr_nxt = pick;
                    adr_nxt    = pick ? s_adr[2*AW-1:AW+2] : s_adr[AW-1:2];
                    dat_nxt    = pick ? s_dat[63:32] : s_dat[31:0];
                    sel_nxt    = pick ? s_sel[7:4] : s_sel[3:0];
                    if (s_we[pick]) begin
                        state_nxt = WR;
                        aw_nxt    = 1'b1;
                        w_nxt     = 1'b1;
                    end else begin
                        state_nxt = RD_A;
                    end
                end
            end
            WR: begin
                aw_nxt = m_awvalid & ~m_awready;
                w_nxt  = m_wvalid & ~m_wready;
                if (!aw_nxt && !w_nxt) begin
                    state_nxt = WRESP;
                end
            end
            WRESP: begin
                if (m_bvalid) begin
                    state_nxt = ACK;
                    err_nxt   = m_bresp[1];
                end
            end
            RD_A: begin
                if (m_arready) begin
                    state_nxt = RD_D;
                end
            end
            RD_D: begin
                if (m_rvalid) begin
                    state_nxt = ACK;
                    rdt_nxt   = m_rdata;
                    err_nxt   = m_rresp[1];
                end
            end
            ACK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        ack_nxt = 2'b00;
        if (state_nxt == ACK) begin
            ack_nxt = grant_nxt ? 2'b10 : 2'b01;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= 1'b0;
            rr_ptr    <= 1'b1;
            adr_q     <= '0;
            m_wdata   <= '0;
            m_wstrb   <= '0;
            m_awvalid <= 1'b0;
            m_wvalid  <= 1'b0;
            m_bready  <= 1'b0;
            m_arvalid <= 1'b0;
            m_rready  <= 1'b0;
            s_ack     <= 2'b00;
            s_rdt     <= '0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            rr_ptr    <= rr_ptr_nxt;
            adr_q     <= adr_nxt;
            m_wdata   <= dat_nxt;
            m_wstrb   <= sel_nxt;
            m_awvalid <= aw_nxt;
            m_wvalid  <= w_nxt;
            m_bready  <= (state_nxt == WRESP);
            m_arvalid <= (state_nxt == RD_A);
            m_rready  <= (state_nxt == RD_D);
            s_ack     <= ack_nxt;
            s_rdt     <= rdt_nxt;
        end
    end

`ifdef SERV_ARB_ERR_EN
    // Error flag travels with the acknowledge of the granted requester
    always_ff @(posedge clk) begin
        if (rst) begin
            s_err <= 2'b00;
        end else begin
            s_err <= ack_nxt & {2{err_nxt}};
        end
    end

    logic unused;
    assign unused = &{1'b0, m_bresp[0], m_rresp[0], s_adr[1:0], s_adr[AW+1:AW]};
`else
    assign s_err = 2'b00;

    logic unused;
    assign unused = &{1'b0, err_nxt, m_bresp, m_rresp, s_adr[1:0], s_adr[AW+1:AW]};
`endif

endmodule

// File: tb/tb_serv_wb2axi_arbiter.sv
// Self-checking bench for serv_wb2axi_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model.
module tb_serv_wb2axi_arbiter;

    localparam int unsigned AW = 13;
`ifdef SERV_ARB_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [2*AW-1:0] s_adr = '0;
    logic [63:0]     s_dat = '0;
    logic [7:0]      s_sel = '0;
    logic [1:0]      s_we = '0;
    logic [1:0]      s_stb = '0;
    logic [1:0]      fp_stb = '0;
    logic            m_awready = 1'b0, m_wready = 1'b0, m_bvalid = 1'b0;
    logic            m_arready = 1'b0, m_rvalid = 1'b0;
    logic [1:0]      m_bresp = '0, m_rresp = '0;
    logic [31:0]     m_rdata = '0;

    wire [1:0]    s_ack, s_err, fp_ack, fp_err;
    wire [31:0]   s_rdt, fp_rdt, m_wdata, fp_wdata;
    wire          m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    wire          fp_awvalid, fp_wvalid, fp_bready, fp_arvalid, fp_rready;
    wire [AW-1:0] m_awaddr, m_araddr, fp_awaddr, fp_araddr;
    wire [3:0]    m_wstrb, fp_wstrb;

    always #5 clk = ~clk;

    serv_wb2axi_arbiter #(.AW(AW), .RR(1'b1)) dut (
        .clk(clk), .rst(rst), .s_adr(s_adr), .s_dat(s_dat), .s_sel(s_sel), .s_we(s_we),
        .s_stb(s_stb), .s_ack(s_ack), .s_err(s_err), .s_rdt(s_rdt),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
    );

    // Fixed-priority variant, only given requests during the arbitration scenario
    serv_wb2axi_arbiter #(.AW(AW), .RR(1'b0)) dut_fp (
        .clk(clk), .rst(rst), .s_adr(s_adr), .s_dat(s_dat), .s_sel(s_sel), .s_we(s_we),
        .s_stb(fp_stb), .s_ack(fp_ack), .s_err(fp_err), .s_rdt(fp_rdt),
        .m_awvalid(fp_awvalid), .m_awready(m_awready), .m_awaddr(fp_awaddr),
        .m_wvalid(fp_wvalid), .m_wready(m_wready), .m_wdata(fp_wdata), .m_wstrb(fp_wstrb),
        .m_bvalid(m_bvalid), .m_bready(fp_bready), .m_bresp(m_bresp),
        .m_arvalid(fp_arvalid), .m_arready(m_arready), .m_araddr(fp_araddr),
        .m_rvalid(m_rvalid), .m_rready(fp_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
    );

    typedef struct packed {
        logic [AW-1:0] adr;
        logic [31:0]   dat;
        logic [3:0]    sel;
        logic          we;
    } req_t;

    req_t cur [2];
    req_t nxt [2];
    bit   act [2];
    int   gap [2];
    int   left [2];
    bit   rand_mode = 1'b0;
    int   errors = 0, checks = 0, acks = 0;

    // Expected DUT outputs for the current cycle
    logic          e_awv = 0, e_wv = 0, e_bready = 0, e_arv = 0, e_rready = 0;
    logic [1:0]    e_ack = 0, e_err = 0;
    logic [31:0]   e_rdt = 0, e_wdata = 0;
    logic [3:0]    e_wstrb = 0;
    logic [AW-1:0] e_addr = 0;
    bit            busy = 0;
    int            g = 0, ptr = 1;

    function automatic req_t mk(input logic [AW-1:0] a, input logic [31:0] d,
                                input logic [3:0] s, input logic w);
        req_t r;
        r.adr = a; r.dat = d; r.sel = s; r.we = w;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, want, $time);
        end
    endtask

    task automatic slave_idle();
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0;
        m_bresp = 0; m_rresp = 0; m_rdata = 0;
    endtask

    task automatic drive_slave_rand();
        m_awready = 1'($urandom);
        m_wready  = 1'($urandom);
        m_arready = 1'($urandom);
        m_bvalid  = e_bready && ($urandom_range(0, 2) == 0);
        m_rvalid  = e_rready && ($urandom_range(0, 2) == 0);
        m_bresp   = 2'($urandom);
        m_rresp   = 2'($urandom);
        m_rdata   = $urandom;
        rst       = ($urandom_range(0, 599) == 0);
    endtask

    // Requesters hold their strobe until acknowledged, then optionally issue the next one
    task automatic drive_reqs();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                act[i] = 0;
            end else begin
                if (act[i] && e_ack[i]) begin
                    act[i] = 0;
                    acks++;
                    gap[i] = rand_mode ? int'($urandom_range(0, 3)) : 0;
                end
                if (!act[i]) begin
                    if (gap[i] > 0) begin
                        gap[i]--;
                    end else if (left[i] > 0) begin
                        left[i]--;
                        act[i] = 1;
                        cur[i] = rand_mode ? mk(AW'($urandom), $urandom, 4'($urandom), 1'($urandom))
                                           : nxt[i];
                    end
                end
            end
        end
        s_stb = {act[1], act[0]};
        s_adr = {cur[1].adr, cur[0].adr};
        s_dat = {cur[1].dat, cur[0].dat};
        s_sel = {cur[1].sel, cur[0].sel};
        s_we  = {cur[1].we, cur[0].we};
    endtask

    task automatic compare();
        chk("ctl", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, s_ack, s_err},
                   {e_awv, e_wv, e_bready, e_arv, e_rready, e_ack, e_err});
        chk("rdt", s_rdt, e_rdt);
        if (e_awv) chk("awaddr", m_awaddr, e_addr);
        if (e_arv) chk("araddr", m_araddr, e_addr);
        if (e_wv)  chk("wdata", {m_wstrb, m_wdata}, {e_wstrb, e_wdata});
    endtask

    // Transaction-level model: what the bus must show next cycle given this cycle's inputs
    task automatic model_update();
        logic          n_awv, n_wv, n_bready, n_arv, n_rready;
        logic [1:0]    n_ack, n_err;
        logic [31:0]   n_rdt;
        n_awv = e_awv; n_wv = e_wv; n_bready = e_bready; n_arv = e_arv; n_rready = e_rready;
        n_ack = 0; n_err = 0; n_rdt = e_rdt;
        if (rst) begin
            n_awv = 0; n_wv = 0; n_bready = 0; n_arv = 0; n_rready = 0;
            n_rdt = 0; busy = 0; ptr = 1;
        end else if (e_ack != 0) begin
            busy = 0;
        end else if (!busy && s_stb != 0) begin
            if (s_stb == 2'b11) g = 1 - ptr;
            else g = s_stb[1] ? 1 : 0;
            ptr = g;
            busy = 1;
            e_addr  = cur[g].adr & ~AW'(3);
            e_wdata = cur[g].dat;
            e_wstrb = cur[g].sel;
            if (cur[g].we) begin
                n_awv = 1; n_wv = 1;
            end else begin
                n_arv = 1;
            end
        end else if (busy) begin
            if (e_awv || e_wv) begin
                n_awv = e_awv && !m_awready;
                n_wv  = e_wv && !m_wready;
                n_bready = !n_awv && !n_wv;
            end else if (e_bready) begin
                if (m_bvalid) begin
                    n_bready = 0;
                    n_ack = 2'(1 << g);
                    n_err = ERR ? (n_ack & {2{m_bresp[1]}}) : 2'b00;
                end
            end else if (e_arv) begin
                if (m_arready) begin
                    n_arv = 0; n_rready = 1;
                end
            end else if (e_rready) begin
                if (m_rvalid) begin
                    n_rready = 0;
                    n_rdt = m_rdata;
                    n_ack = 2'(1 << g);
                    n_err = ERR ? (n_ack & {2{m_rresp[1]}}) : 2'b00;
                end
            end
        end
        e_awv = n_awv; e_wv = n_wv; e_bready = n_bready; e_arv = n_arv; e_rready = n_rready;
        e_ack = n_ack; e_err = n_err; e_rdt = n_rdt;
    endtask

    // One clock cycle: drive inputs, check outputs, advance the model
    task automatic step();
        if (rand_mode) drive_slave_rand();
        drive_reqs();
        compare();
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1;
        step();
        step();
        rst = 0;
        for (int i = 0; i < 2; i++) begin
            left[i] = 0;
            gap[i] = 0;
        end
    endtask

    initial begin
        int ord [8];
        int n, fpn, cnt_aw, cnt_w, cnt_r, first_b, ack_cyc;
        bit seen;
        for (int i = 0; i < 2; i++) begin
            act[i] = 0; gap[i] = 0; left[i] = 0;
            cur[i] = mk('0, '0, '0, 1'b0);
            nxt[i] = mk('0, '0, '0, 1'b0);
        end
        @(negedge clk);
        do_reset();
        chk("reset_outs", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, s_ack, s_err, s_rdt},
                          41'd0);

        // req0 write with a zero-wait slave
        slave_idle(); m_awready = 1; m_wready = 1;
        nxt[0] = mk(13'h0106, 32'hDEADBEEF, 4'hF, 1'b1); left[0] = 1;
        step();
        chk("t1_valid", {m_awvalid, m_wvalid}, 2'b11);
        chk("t1_awaddr", m_awaddr, 13'h0104);
        chk("t1_wdata", m_wdata, 32'hDEADBEEF);
        step();
        m_bvalid = 1;
        chk("t1_bready_c2", m_bready, 1'b1);
        chk("t1_ack_c2", s_ack, 2'b00);
        step();
        m_bvalid = 0;
        chk("t1_ack_c3", s_ack, 2'b01);
        step();
        chk("t1_ack_c4", s_ack, 2'b00);

        // Simultaneous reads, immediately re-issued; fixed-priority copy sees the same ties
        do_reset();
        slave_idle(); m_arready = 1; m_rvalid = 1; m_bvalid = 1;
        nxt[0] = mk(13'h0040, 0, 4'hF, 1'b0); nxt[1] = mk(13'h0080, 0, 4'hF, 1'b0);
        left[0] = 2; left[1] = 2;
        fp_stb = 2'b11;
        n = 0; fpn = 0;
        for (int k = 0; k < 8; k++) ord[k] = -1;
        for (int c = 0; c < 20; c++) begin
            if (s_ack != 0 && n < 8) begin
                ord[n] = s_ack[1] ? 1 : 0;
                n++;
            end
            if (fp_ack != 0) begin
                chk("t2_fp_grant", fp_ack, 2'b01);
                fpn++;
            end
            step();
        end
        chk("t2_count", n, 4);
        for (int k = 0; k < 4; k++) chk("t2_order", ord[k], k % 2);
        chk("t2_fp_progress", fpn >= 4, 1);
        fp_stb = 2'b00;

        // Write with the address channel stalled three cycles
        do_reset();
        slave_idle();
        nxt[0] = mk(13'h0200, 32'hA5A5_0F0F, 4'h3, 1'b1); left[0] = 1;
        cnt_aw = 0; cnt_w = 0; first_b = -1; ack_cyc = -1;
        for (int c = 0; c < 10; c++) begin
            m_awready = (c == 4);
            m_wready  = 1;
            m_bvalid  = (c == 6);
            cnt_aw += int'(m_awvalid);
            cnt_w  += int'(m_wvalid);
            if (m_bready && first_b < 0) first_b = c;
            if (s_ack != 0) ack_cyc = c;
            step();
        end
        chk("t3_awvalid_cycles", cnt_aw, 4);
        chk("t3_wvalid_cycles", cnt_w, 1);
        chk("t3_first_bready", first_b, 5);
        chk("t3_ack_cycle", ack_cyc, 7);

        // req1 read with a late read response
        do_reset();
        slave_idle(); m_arready = 1;
        nxt[1] = mk(13'h0ABC, 0, 4'hF, 1'b0); left[1] = 1;
        cnt_r = 0; seen = 0;
        for (int c = 0; c < 12; c++) begin
            m_rvalid = (c == 7);
            m_rdata  = (c == 7) ? 32'h12345678 : $urandom;
            cnt_r += int'(m_rready);
            if (s_ack != 0) begin
                seen = 1;
                chk("t4_ack", s_ack, 2'b10);
                chk("t4_rdt", s_rdt, 32'h12345678);
                chk("t4_ack_cycle", c, 8);
            end
            step();
        end
        chk("t4_rready_cycles", cnt_r, 6);
        chk("t4_ack_seen", seen, 1);

        // Reset while waiting for read data, then a normal write
        slave_idle(); m_arready = 1;
        nxt[0] = mk(13'h0010, 0, 4'hF, 1'b0); left[0] = 1;
        step(); step(); step();
        chk("t5_in_rd_d", m_rready, 1'b1);
        rst = 1;
        step();
        rst = 0;
        chk("t5_after_rst", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, s_ack, s_err, s_rdt},
                            41'd0);
        slave_idle(); m_awready = 1; m_wready = 1; m_bvalid = 1;
        nxt[0] = mk(13'h0020, 32'h0BAD_F00D, 4'hC, 1'b1); left[0] = 1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (s_ack == 2'b01) seen = 1;
            step();
        end
        chk("t5_write_done", seen, 1);

        // Read returning SLVERR
        do_reset();
        slave_idle(); m_arready = 1; m_rvalid = 1; m_rresp = 2'b10; m_rdata = 32'h5555AAAA;
        nxt[0] = mk(13'h0030, 0, 4'hF, 1'b0); left[0] = 1;
        seen = 0;
        for (int c = 0; c < 7; c++) begin
            if (s_ack != 0) begin
                seen = 1;
                chk("t6_err", s_err, ERR ? 2'b01 : 2'b00);
            end
            step();
        end
        chk("t6_ack_seen", seen, 1);

        // Randomized traffic, occasional resets
        do_reset();
        slave_idle();
        acks = 0;
        rand_mode = 1;
        left[0] = 100000; left[1] = 100000;
        for (int c = 0; c < 4000; c++) step();
        rand_mode = 0;
        rst = 0;
        chk("rand_progress", acks > 200, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
